// File: rtl/histo_pkg.sv
// Shared types and constants for the histogram-side pixel consumers.
package histo_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_PUBLISH = 2'd3
  } frame_st_e;

  localparam int unsigned DRAIN_CYC   = 2;
  localparam int unsigned DRAIN_CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [15:0] PIX_FG = 16'hFFFF;
  localparam logic [15:0] PIX_BG = 16'h0000;

endpackage

// File: rtl/bbox_acc.sv
// Running min/max of X and Y over the foreground pixels of one frame.
module bbox_acc #(
  parameter int unsigned COORD_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_upd,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [COORD_W-1:0] o_min_x,
  output logic [COORD_W-1:0] o_max_x,
  output logic [COORD_W-1:0] o_min_y,
  output logic [COORD_W-1:0] o_max_y
);

  // Clear seeds min at all-ones and max at zero so the first update wins both.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_min_x <= '0;
      o_max_x <= '0;
      o_min_y <= '0;
      o_max_y <= '0;
    end else if (i_clear) begin
      o_min_x <= '1;
      o_max_x <= '0;
      o_min_y <= '1;
      o_max_y <= '0;
    end else if (i_upd) begin
      if (i_x < o_min_x) o_min_x <= i_x;
      if (i_x > o_max_x) o_max_x <= i_x;
      if (i_y < o_min_y) o_min_y <= i_y;
      if (i_y > o_max_y) o_max_y <= i_y;
    end
  end

endmodule

// File: rtl/histo_binarize.sv
// Thresholds the grey stream against the per-frame histogram bin and
// publishes foreground count and bounding box once each frame completes.
module histo_binarize
  import histo_pkg::*;
#(
  parameter int unsigned GREY_W  = 12,
  parameter int unsigned TH_W    = 8,
  parameter int unsigned COORD_W = 16,
  parameter int unsigned CNT_W   = 20
) (
  input  logic               iPclk,
  input  logic               iRST_N,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  input  logic               Dval,
  input  logic               Fval,
  input  logic [GREY_W-1:0]  Grey,
  input  logic [TH_W-1:0]    iThresh,
  output logic [15:0]        oBinPix,
  output logic               oBinDval,
  output logic [CNT_W-1:0]   oFgCount,
  output logic [COORD_W-1:0] oMinX,
  output logic [COORD_W-1:0] oMaxX,
  output logic [COORD_W-1:0] oMinY,
  output logic [COORD_W-1:0] oMaxY,
  output logic               oBoxValid,
  output logic               oStatStb,
  output logic [TH_W-1:0]    oThreshUsed
);

  localparam int unsigned GREY_LSB = GREY_W - TH_W;

  frame_st_e                r_state;
  frame_st_e                w_state_nxt;
  logic [DRAIN_CNT_W-1:0]   r_drain_cnt;
  logic                     r_fval_d;
  logic                     r_armed;
  logic                     r_fall;
  logic                     w_rise;
  logic                     w_clear;
  logic                     w_publish;
  logic                     w_acc_en;
  logic                     w_fg;

  logic [TH_W-1:0]          r_s1_bin;
  logic                     r_s1_dval;
  logic                     r_s1_fv;
  logic [COORD_W-1:0]       r_s1_x;
  logic [COORD_W-1:0]       r_s1_y;
  logic                     r_s2_acc;
  logic [COORD_W-1:0]       r_s2_x;
  logic [COORD_W-1:0]       r_s2_y;

  logic [CNT_W-1:0]         r_fg_cnt;
  logic                     w_box_any;
  logic [COORD_W-1:0]       w_min_x;
  logic [COORD_W-1:0]       w_max_x;
  logic [COORD_W-1:0]       w_min_y;
  logic [COORD_W-1:0]       w_max_y;
  logic                     w_grey_lsb_unused;

  assign w_grey_lsb_unused = ^Grey[GREY_LSB-1:0];

  // r_armed blocks a false rise when reset releases in the middle of a frame.
  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_fval_d <= 1'b0;
      r_armed  <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_fval_d <= Fval;
      r_armed  <= r_armed | ~Fval;
      r_fall   <= r_fval_d & ~Fval;
    end
  end

  assign w_rise = Fval & ~r_fval_d & r_armed;

  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      oThreshUsed <= '0;
    end else if (w_rise) begin
      oThreshUsed <= iThresh;
    end
  end

  // Stage 1: capture pixel, qualifiers and coordinates.
  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_s1_bin  <= '0;
      r_s1_dval <= 1'b0;
      r_s1_fv   <= 1'b0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
    end else begin
      r_s1_bin  <= Grey[GREY_W-1 -: TH_W];
      r_s1_dval <= Dval;
      r_s1_fv   <= Fval;
      r_s1_x    <= iX_Cont;
      r_s1_y    <= iY_Cont;
    end
  end

  assign w_fg = r_s1_bin > oThreshUsed;

  // Stage 2: binary pixel out, plus the accumulate request for in-frame foreground.
  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      oBinPix  <= PIX_BG;
      oBinDval <= 1'b0;
      r_s2_acc <= 1'b0;
      r_s2_x   <= '0;
      r_s2_y   <= '0;
    end else begin
      oBinPix  <= (r_s1_dval & w_fg) ? PIX_FG : PIX_BG;
      oBinDval <= r_s1_dval;
      r_s2_acc <= r_s1_dval & r_s1_fv & w_fg;
      r_s2_x   <= r_s1_x;
      r_s2_y   <= r_s1_y;
    end
  end

  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_publish   = 1'b0;
    unique case (r_state)
      ST_WAIT: begin
        if (w_rise) begin
          w_state_nxt = ST_RUN;
          w_clear     = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_fall) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == DRAIN_CNT_W'(DRAIN_CYC - 1)) w_state_nxt = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        w_publish = 1'b1;
        if (Fval) begin
          w_state_nxt = ST_RUN;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_drain_cnt <= '0;
    end else if (r_state != ST_DRAIN) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + DRAIN_CNT_W'(1);
    end
  end

  assign w_acc_en = r_s2_acc & ((r_state == ST_RUN) | (r_state == ST_DRAIN));

  // Saturating foreground counter.
  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_fg_cnt <= '0;
    end else if (w_clear) begin
      r_fg_cnt <= '0;
    end else if (w_acc_en && (r_fg_cnt != '1)) begin
      r_fg_cnt <= r_fg_cnt + CNT_W'(1);
    end
  end

  bbox_acc #(
    .COORD_W (COORD_W)
  ) u_bbox (
    .i_clk   (iPclk),
    .i_rst_n (iRST_N),
    .i_clear (w_clear),
    .i_upd   (w_acc_en),
    .i_x     (r_s2_x),
    .i_y     (r_s2_y),
    .o_min_x (w_min_x),
    .o_max_x (w_max_x),
    .o_min_y (w_min_y),
    .o_max_y (w_max_y)
  );

  assign w_box_any = |r_fg_cnt;

  // Statistics hold between publishes; an empty frame reports a zero box.
  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      oStatStb  <= 1'b0;
      oFgCount  <= '0;
      oBoxValid <= 1'b0;
      oMinX     <= '0;
      oMaxX     <= '0;
      oMinY     <= '0;
      oMaxY     <= '0;
    end else begin
      oStatStb <= w_publish;
      if (w_publish) begin
        oFgCount  <= r_fg_cnt;
        oBoxValid <= w_box_any;
        oMinX     <= w_box_any ? w_min_x : '0;
        oMaxX     <= w_box_any ? w_max_x : '0;
        oMinY     <= w_box_any ? w_min_y : '0;
        oMaxY     <= w_box_any ? w_max_y : '0;
      end
    end
  end

endmodule

// File: tb/tb_histo_binarize.sv
// Randomized bench for histo_binarize against a per-frame reference model.
module tb_histo_binarize;

  logic        clk;
  logic        rst_n;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        dval;
  logic        fval;
  logic [11:0] grey;
  logic [7:0]  thresh;

  logic [15:0] bin_pix;
  logic        bin_dval;
  logic [19:0] fg_count;
  logic [15:0] min_x, max_x, min_y, max_y;
  logic        box_valid;
  logic        stat_stb;
  logic [7:0]  thresh_used;

  logic [3:0]  s_fg_count;
  logic        s_box_valid;
  logic        s_stat_stb;
  logic [15:0] s_unused_pix;
  logic        s_unused_dval;
  logic [15:0] s_unused_minx, s_unused_maxx, s_unused_miny, s_unused_maxy;
  logic [7:0]  s_unused_thr;

  histo_binarize #(.GREY_W(12), .TH_W(8), .COORD_W(16), .CNT_W(20)) dut (
    .iPclk(clk), .iRST_N(rst_n), .iX_Cont(x_in), .iY_Cont(y_in),
    .Dval(dval), .Fval(fval), .Grey(grey), .iThresh(thresh),
    .oBinPix(bin_pix), .oBinDval(bin_dval), .oFgCount(fg_count),
    .oMinX(min_x), .oMaxX(max_x), .oMinY(min_y), .oMaxY(max_y),
    .oBoxValid(box_valid), .oStatStb(stat_stb), .oThreshUsed(thresh_used)
  );

  // Narrow counter instance: same stimulus, saturates at 15.
  histo_binarize #(.GREY_W(12), .TH_W(8), .COORD_W(16), .CNT_W(4)) dut_sat (
    .iPclk(clk), .iRST_N(rst_n), .iX_Cont(x_in), .iY_Cont(y_in),
    .Dval(dval), .Fval(fval), .Grey(grey), .iThresh(thresh),
    .oBinPix(s_unused_pix), .oBinDval(s_unused_dval), .oFgCount(s_fg_count),
    .oMinX(s_unused_minx), .oMaxX(s_unused_maxx), .oMinY(s_unused_miny), .oMaxY(s_unused_maxy),
    .oBoxValid(s_box_valid), .oStatStb(s_stat_stb), .oThreshUsed(s_unused_thr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit         m_prev_f, m_armed, m_in_frame, m_pend;
  logic [7:0] m_thr;
  bit         m_pipe_dv, m_pipe_fg;
  int         m_cd;
  int         m_cnt, m_minx, m_maxx, m_miny, m_maxy;
  int         p_cnt, p_minx, p_maxx, p_miny, p_maxy;
  bit         e_dv, e_pix, e_stb, e_valid;
  int         e_cnt, e_minx, e_maxx, e_miny, e_maxy;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_prev_f = 0; m_armed = 0; m_in_frame = 0; m_pend = 0; m_thr = 8'h00;
    m_pipe_dv = 0; m_pipe_fg = 0; m_cd = 0;
    m_cnt = 0; m_minx = 0; m_maxx = 0; m_miny = 0; m_maxy = 0;
    e_dv = 0; e_pix = 0; e_stb = 0; e_valid = 0;
    e_cnt = 0; e_minx = 0; e_maxx = 0; e_miny = 0; e_maxy = 0;
  endtask

  task automatic model_step(input bit d, input bit f, input logic [11:0] g,
                            input int xx, input int yy, input logic [7:0] th);
    bit rise, fall, fg;
    rise = f && !m_prev_f && m_armed;
    fall = !f && m_prev_f && m_in_frame;
    e_dv  = m_pipe_dv;
    e_pix = m_pipe_fg;
    e_stb = 0;
    if (m_pend) begin
      m_cd--;
      if (m_cd == 0) begin
        m_pend  = 0;
        e_stb   = 1;
        e_cnt   = p_cnt;
        e_valid = (p_cnt != 0);
        e_minx  = e_valid ? p_minx : 0;
        e_maxx  = e_valid ? p_maxx : 0;
        e_miny  = e_valid ? p_miny : 0;
        e_maxy  = e_valid ? p_maxy : 0;
      end
    end
    if (rise) begin
      m_thr = th; m_in_frame = 1;
      m_cnt = 0; m_minx = 65535; m_maxx = 0; m_miny = 65535; m_maxy = 0;
    end
    fg = (g[11:4] > m_thr);
    if (d && f && m_in_frame && fg) begin
      m_cnt++;
      if (xx < m_minx) m_minx = xx;
      if (xx > m_maxx) m_maxx = xx;
      if (yy < m_miny) m_miny = yy;
      if (yy > m_maxy) m_maxy = yy;
    end
    if (fall) begin
      m_pend = 1; m_cd = 4; m_in_frame = 0;
      p_cnt = m_cnt; p_minx = m_minx; p_maxx = m_maxx; p_miny = m_miny; p_maxy = m_maxy;
    end
    m_pipe_dv = d;
    m_pipe_fg = d && fg;
    m_prev_f  = f;
    m_armed   = m_armed || !f;
  endtask

  task automatic check_outputs();
    chk("bin_dval", 32'(bin_dval), 32'(e_dv));
    chk("bin_pix", 32'(bin_pix), e_pix ? 32'h0000FFFF : 32'h0);
    chk("stat_stb", 32'(stat_stb), 32'(e_stb));
    chk("thresh_used", 32'(thresh_used), 32'(m_thr));
    chk("fg_count", 32'(fg_count), sat(e_cnt, 32'hFFFFF));
    chk("box_valid", 32'(box_valid), 32'(e_valid));
    chk("min_x", 32'(min_x), e_minx);
    chk("max_x", 32'(max_x), e_maxx);
    chk("min_y", 32'(min_y), e_miny);
    chk("max_y", 32'(max_y), e_maxy);
    chk("sat_fg_count", 32'(s_fg_count), sat(e_cnt, 15));
    chk("sat_box_valid", 32'(s_box_valid), 32'(e_valid));
    chk("sat_stat_stb", 32'(s_stat_stb), 32'(e_stb));
  endtask

  task automatic drive(input bit d, input bit f, input logic [11:0] g,
                       input logic [15:0] xx, input logic [15:0] yy, input logic [7:0] th);
    dval = d; fval = f; grey = g; x_in = xx; y_in = yy; thresh = th;
    @(posedge clk);
    #1;
    model_step(d, f, g, int'(xx), int'(yy), th);
    check_outputs();
  endtask

  task automatic blank(input int n, input logic [7:0] th);
    bit sd;
    for (int i = 0; i < n; i++) begin
      sd = ($urandom_range(0, 3) == 0);
      drive(sd, 1'b0, 12'($urandom), 16'($urandom), 16'($urandom), th);
    end
  endtask

  // Blanking, one w x h frame, blanking. Threshold input switches to th_mid halfway.
  task automatic run_frame(input int w, input int h, input int x0, input int y0,
                           input bit rnd, input logic [11:0] bg, input int fx, input int fy,
                           input logic [7:0] th, input logic [7:0] th_mid, input bit gaps);
    int n;
    logic [7:0]  thc;
    logic [11:0] g;
    n = 0;
    blank(8, th);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        thc = (n >= (w * h) / 2) ? th_mid : th;
        if (gaps && $urandom_range(0, 3) == 0)
          drive(1'b0, 1'b1, 12'($urandom), 16'($urandom), 16'($urandom), thc);
        if (xx == fx && yy == fy) g = 12'hFFF;
        else                      g = rnd ? 12'($urandom) : bg;
        drive(1'b1, 1'b1, g, 16'(x0 + xx), 16'(y0 + yy), thc);
        n++;
      end
    end
    blank(8, th_mid);
  endtask

  initial begin
    rst_n = 1'b0; dval = 1'b0; fval = 1'b0; grey = '0; x_in = '0; y_in = '0; thresh = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // All-foreground 4x4 frame
    run_frame(4, 4, 0, 0, 0, 12'hFF0, -1, -1, 8'hFE, 8'hFE, 0);
    chk("t1_count", 32'(fg_count), 32'd16);
    chk("t1_box", {min_x[7:0], max_x[7:0], min_y[7:0], max_y[7:0]}, 32'h00030003);
    chk("t1_valid", 32'(box_valid), 32'd1);
    chk("t1_sat_count", 32'(s_fg_count), 32'd15);

    // Bin equal to threshold is background
    run_frame(5, 4, 3, 2, 0, 12'h800, -1, -1, 8'h80, 8'h80, 1);
    chk("t2_count", 32'(fg_count), 32'd0);
    chk("t2_valid", 32'(box_valid), 32'd0);
    chk("t2_box", {min_x, max_x} | {min_y, max_y}, 32'd0);

    // Single foreground pixel in a 64x32 frame
    run_frame(64, 32, 0, 0, 0, 12'h100, 37, 12, 8'h40, 8'h40, 0);
    chk("t3_count", 32'(fg_count), 32'd1);
    chk("t3_box_x", {min_x, max_x}, {16'd37, 16'd37});
    chk("t3_box_y", {min_y, max_y}, {16'd12, 16'd12});

    // Mid-frame threshold change is ignored until the next frame
    run_frame(8, 6, 10, 20, 1, 12'h000, -1, -1, 8'h10, 8'hF0, 1);
    chk("t4_thr_frame", 32'(thresh_used), 32'h10);
    run_frame(8, 6, 10, 20, 1, 12'h000, -1, -1, 8'hF0, 8'hF0, 1);
    chk("t4_thr_next", 32'(thresh_used), 32'hF0);

    // Async reset in the middle of a running frame
    blank(8, 8'h20);
    for (int i = 0; i < 20; i++)
      drive(1'b1, 1'b1, 12'($urandom), 16'(i % 8), 16'(i / 8), 8'h20);
    dval = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 20; i < 40; i++)
      drive(1'b1, 1'b1, 12'hFFF, 16'(i % 8), 16'(i / 8), 8'h20);
    blank(10, 8'h20);
    chk("t5_no_pub_count", 32'(fg_count), 32'd0);
    run_frame(6, 3, 100, 200, 0, 12'hFFF, -1, -1, 8'h20, 8'h20, 0);
    chk("t5_count", 32'(fg_count), 32'd18);
    chk("t5_box", {min_x, min_y}, {16'd100, 16'd200});

    // One-cycle frame
    run_frame(1, 1, 5, 9, 0, 12'hFFF, -1, -1, 8'h00, 8'h00, 0);
    chk("t6_count", 32'(fg_count), 32'd1);
    chk("t6_box", {max_x, max_y}, {16'd5, 16'd9});

    // Random frames
    for (int k = 0; k < 10; k++)
      run_frame(int'($urandom_range(1, 12)), int'($urandom_range(1, 8)),
                int'($urandom_range(0, 500)), int'($urandom_range(0, 500)),
                1, 12'h000, -1, -1, 8'($urandom), 8'($urandom), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
